// File: rtl/decoder_pipe_n_if.sv
// Handshake bundle for decoder_pipe_n: select stream in, one-hot stream out,
// plus the acceptance enable and the error counter.
`timescale 1ns/1ps
interface decoder_pipe_n_if #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_onehot;
  logic               out_err;
  logic [CNT_W-1:0]   err_cnt;

  modport master (
    output en, in_valid, in_sel, out_ready,
    input  in_ready, out_valid, out_onehot, out_err, err_cnt
  );

  modport slave (
    input  en, in_valid, in_sel, out_ready,
    output in_ready, out_valid, out_onehot, out_err, err_cnt
  );
endinterface

// File: rtl/decoder_pipe_n.sv
// Registered binary-to-one-hot decoder with valid/ready handshake, a one-entry
// skid register behind the output register, and a saturating range-error count.
`timescale 1ns/1ps
module decoder_pipe_n #(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int ACTIVE_LOW = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  decoder_pipe_n_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_OUT-1:0] dec_onehot;
  logic               dec_err;
  logic               in_ready;
  logic               accept;
  logic               or_free;

  logic               ready_reg;
  logic               or_valid_reg, or_valid_next;
  logic [NUM_OUT-1:0] or_onehot_reg, or_onehot_next;
  logic               or_err_reg, or_err_next;
  logic               sk_valid_reg, sk_valid_next;
  logic [NUM_OUT-1:0] sk_onehot_reg, sk_onehot_next;
  logic               sk_err_reg, sk_err_next;
  logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next;

  // Out-of-range selects match no line, so the one-hot vector is naturally all zero.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dec
    assign dec_onehot[gi] = (32'(bus.in_sel) == 32'(gi));
  end
  assign dec_err = (32'(bus.in_sel) >= 32'(NUM_OUT));

  assign in_ready = bus.en & ~sk_valid_reg & ready_reg;
  assign accept   = bus.in_valid & in_ready;
  assign or_free  = ~or_valid_reg | bus.out_ready;

  always_comb begin
    or_valid_next  = or_valid_reg;
    or_onehot_next = or_onehot_reg;
    or_err_next    = or_err_reg;
    sk_valid_next  = sk_valid_reg;
    sk_onehot_next = sk_onehot_reg;
    sk_err_next    = sk_err_reg;
    err_cnt_next   = err_cnt_reg;

    if (or_free) begin
      if (sk_valid_reg) begin
        or_valid_next  = 1'b1;
        or_onehot_next = sk_onehot_reg;
        or_err_next    = sk_err_reg;
        sk_valid_next  = 1'b0;
      end else if (accept) begin
        or_valid_next  = 1'b1;
        or_onehot_next = dec_onehot;
        or_err_next    = dec_err;
      end else begin
        // Empty output returns to the idle level rather than holding stale lines.
        or_valid_next  = 1'b0;
        or_onehot_next = '0;
        or_err_next    = 1'b0;
      end
    end else if (accept) begin
      sk_valid_next  = 1'b1;
      sk_onehot_next = dec_onehot;
      sk_err_next    = dec_err;
    end

    if (accept && dec_err && (err_cnt_reg != CNT_MAX)) begin
      err_cnt_next = err_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_reg     <= 1'b0;
      or_valid_reg  <= 1'b0;
      or_onehot_reg <= '0;
      or_err_reg    <= 1'b0;
      sk_valid_reg  <= 1'b0;
      sk_onehot_reg <= '0;
      sk_err_reg    <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      ready_reg     <= 1'b1;
      or_valid_reg  <= or_valid_next;
      or_onehot_reg <= or_onehot_next;
      or_err_reg    <= or_err_next;
      sk_valid_reg  <= sk_valid_next;
      sk_onehot_reg <= sk_onehot_next;
      sk_err_reg    <= sk_err_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  // Lines are stored active-high; polarity is applied only at the pins.
  assign bus.out_onehot = (ACTIVE_LOW != 0) ? ~or_onehot_reg : or_onehot_reg;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = or_valid_reg;
  assign bus.out_err    = or_err_reg;
  assign bus.err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_decoder_pipe_n.sv
// Directed bench for decoder_pipe_n: four parameterisations share one clock
// and reset; expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_decoder_pipe_n;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt     = 0;
  int miscompares = 0;

  decoder_pipe_n_if #(.SEL_W(2), .NUM_OUT(4), .CNT_W(8)) if_a ();
  decoder_pipe_n_if #(.SEL_W(3), .NUM_OUT(6), .CNT_W(8)) if_b ();
  decoder_pipe_n_if #(.SEL_W(2), .NUM_OUT(4), .CNT_W(8)) if_c ();
  decoder_pipe_n_if #(.SEL_W(2), .NUM_OUT(3), .CNT_W(2)) if_d ();

  decoder_pipe_n #(.SEL_W(2), .NUM_OUT(4), .ACTIVE_LOW(0), .CNT_W(8))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  decoder_pipe_n #(.SEL_W(3), .NUM_OUT(6), .ACTIVE_LOW(0), .CNT_W(8))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  decoder_pipe_n #(.SEL_W(2), .NUM_OUT(4), .ACTIVE_LOW(1), .CNT_W(8))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  decoder_pipe_n #(.SEL_W(2), .NUM_OUT(3), .ACTIVE_LOW(0), .CNT_W(2))
    u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("vec %0d %s ok (%0h)", vec_cnt, tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] b_sel [3];
  logic [5:0] b_hot [3];
  logic       b_err [3];

  initial begin
    b_sel[0] = 3'd6; b_hot[0] = 6'b000000; b_err[0] = 1'b1;
    b_sel[1] = 3'd7; b_hot[1] = 6'b000000; b_err[1] = 1'b1;
    b_sel[2] = 3'd2; b_hot[2] = 6'b000100; b_err[2] = 1'b0;

    if_a.en = 1'b1; if_a.in_valid = 1'b0; if_a.in_sel = '0; if_a.out_ready = 1'b1;
    if_b.en = 1'b1; if_b.in_valid = 1'b0; if_b.in_sel = '0; if_b.out_ready = 1'b1;
    if_c.en = 1'b1; if_c.in_valid = 1'b0; if_c.in_sel = '0; if_c.out_ready = 1'b1;
    if_d.en = 1'b1; if_d.in_valid = 1'b0; if_d.in_sel = '0; if_d.out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_a_valid",   32'(if_a.out_valid),  32'd0);
    chk("rst_a_ready",   32'(if_a.in_ready),   32'd0);
    chk("rst_a_onehot",  32'(if_a.out_onehot), 32'h0);
    chk("rst_a_errcnt",  32'(if_a.err_cnt),    32'd0);
    chk("rst_c_idle",    32'(if_c.out_onehot), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_a_ready0",  32'(if_a.in_ready),   32'd0);
    step();
    chk("rel_a_ready1",  32'(if_a.in_ready),   32'd1);

    // Streaming decode, default params
    if_a.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_a.in_sel = 2'(i);
      step();
      chk($sformatf("a_hot_%0d", i),   32'(if_a.out_onehot), 32'(1) << i);
      chk($sformatf("a_valid_%0d", i), 32'(if_a.out_valid),  32'd1);
      chk($sformatf("a_err_%0d", i),   32'(if_a.out_err),    32'd0);
    end
    if_a.in_valid = 1'b0;
    step();
    chk("a_drain_valid", 32'(if_a.out_valid),  32'd0);
    chk("a_drain_idle",  32'(if_a.out_onehot), 32'h0);

    // Out-of-range selects, SEL_W=3 NUM_OUT=6
    if_b.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_b.in_sel = b_sel[i];
      step();
      chk($sformatf("b_hot_%0d", i), 32'(if_b.out_onehot), 32'(b_hot[i]));
      chk($sformatf("b_err_%0d", i), 32'(if_b.out_err),    32'(b_err[i]));
    end
    if_b.in_valid = 1'b0;
    step();
    chk("b_errcnt", 32'(if_b.err_cnt), 32'd2);

    // Backpressure through the skid register
    if_a.out_ready = 1'b0;
    if_a.in_valid  = 1'b1;
    if_a.in_sel    = 2'd1;
    step();
    chk("bp_hot1",   32'(if_a.out_onehot), 32'h2);
    chk("bp_ready1", 32'(if_a.in_ready),   32'd1);
    if_a.in_sel = 2'd2;
    step();
    if_a.in_valid = 1'b0;
    chk("bp_ready_full", 32'(if_a.in_ready),   32'd0);
    chk("bp_hold_hot",   32'(if_a.out_onehot), 32'h2);
    step();
    chk("bp_hold_hot2",  32'(if_a.out_onehot), 32'h2);
    chk("bp_hold_valid", 32'(if_a.out_valid),  32'd1);
    if_a.out_ready = 1'b1;
    step();
    chk("bp_second_hot", 32'(if_a.out_onehot), 32'h4);
    chk("bp_ready_back", 32'(if_a.in_ready),   32'd1);
    step();
    chk("bp_empty",      32'(if_a.out_valid),  32'd0);

    // Active-low polarity
    chk("c_idle", 32'(if_c.out_onehot), 32'hF);
    if_c.in_valid = 1'b1;
    if_c.in_sel   = 2'd2;
    step();
    if_c.in_valid = 1'b0;
    chk("c_hot",   32'(if_c.out_onehot), 32'hB);
    chk("c_valid", 32'(if_c.out_valid),  32'd1);
    step();
    chk("c_back_idle", 32'(if_c.out_onehot), 32'hF);

    // Saturating counter, CNT_W=2 NUM_OUT=3
    if_d.in_valid = 1'b1;
    if_d.in_sel   = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("d_cnt_%0d", i), 32'(if_d.err_cnt),    (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("d_err_%0d", i), 32'(if_d.out_err),    32'd1);
      chk($sformatf("d_hot_%0d", i), 32'(if_d.out_onehot), 32'h0);
    end
    if_d.in_valid = 1'b0;
    step();

    // Dropping en mid-stream still drains OR and SK
    if_a.out_ready = 1'b0;
    if_a.in_valid  = 1'b1;
    if_a.in_sel    = 2'd0;
    step();
    if_a.in_sel = 2'd1;
    step();
    if_a.in_valid = 1'b1;
    if_a.in_sel   = 2'd3;
    if_a.en       = 1'b0;
    #1;
    chk("en_ready0", 32'(if_a.in_ready), 32'd0);
    if_a.out_ready = 1'b1;
    step();
    chk("en_drain_sk", 32'(if_a.out_onehot), 32'h2);
    chk("en_ready_off", 32'(if_a.in_ready),  32'd0);
    step();
    chk("en_drained", 32'(if_a.out_valid), 32'd0);
    if_a.in_valid = 1'b0;
    if_a.en       = 1'b1;

    // Asynchronous reset with OR and SK full
    if_a.out_ready = 1'b0;
    if_a.in_valid  = 1'b1;
    if_a.in_sel    = 2'd0;
    step();
    if_a.in_sel = 2'd1;
    step();
    if_a.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(if_a.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a_valid",  32'(if_a.out_valid),  32'd0);
    chk("arst_a_onehot", 32'(if_a.out_onehot), 32'h0);
    chk("arst_b_errcnt", 32'(if_b.err_cnt),    32'd0);
    chk("arst_d_errcnt", 32'(if_d.err_cnt),    32'd0);
    chk("arst_c_idle",   32'(if_c.out_onehot), 32'hF);
    if_b.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arel_a_ready0", 32'(if_a.in_ready), 32'd0);
    step();
    chk("arel_a_ready1", 32'(if_a.in_ready), 32'd1);
    chk("arel_b_ready",  32'(if_b.in_ready), 32'd0);
    step();
    chk("arel_b_ready2", 32'(if_b.in_ready),  32'd0);
    chk("arel_a_empty",  32'(if_a.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
